// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: syncs/filters the raw lines, deframes 11-bit frames and folds E0/F0
// prefixes into one 32-bit event word. Optional PS2_TYPEMATIC_FILTER_EN suppresses repeated makes.
module ps2_keyboard_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2Clk,
  input  logic        ps2Dat,
  output logic [31:0] ps2Data,
  output logic        newEvent,
  output logic        frameErr
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt, filt_q;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  state_t        state, eff_state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;

  logic          ext_pend, brk_pend;
  logic [7:0]    ev_code, ev_cnt, err_cnt;
  logic          ev_brk, ev_ext;

  logic          timeout, start_err, stop_done, byte_ok, frame_bad;
  logic          is_e0, is_f0, is_key, emit;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0]    last_make;
  logic          last_vld;
  logic          key_match;
`endif

  // Input synchronisers and clock-line glitch filter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      filt    <= 1'b1;
      filt_q  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_s1 <= ps2Clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2Dat;
      dat_s2 <= dat_s1;
      filt_q <= filt;
      if (clk_s2 == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        filt    <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall = filt_q & ~filt;

  // A timeout forces IDLE first, so a coincident edge is treated as a fresh start bit.
  always_comb begin
    timeout   = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES));
    eff_state = timeout ? IDLE : state;
    start_err = fall && (eff_state == IDLE) && dat_s2;
    stop_done = fall && (eff_state == STOP);
    byte_ok   = stop_done && dat_s2 && (^{par, shreg});
    frame_bad = timeout || start_err || (stop_done && !byte_ok);
    is_e0     = (shreg == 8'hE0);
    is_f0     = (shreg == 8'hF0);
    is_key    = byte_ok && !is_e0 && !is_f0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    key_match = last_vld && (last_make == {ext_pend, shreg});
    emit      = is_key && !(key_match && !brk_pend);
`else
    emit      = is_key;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      bitcnt   <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tcnt     <= '0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      ev_code  <= '0;
      ev_brk   <= 1'b0;
      ev_ext   <= 1'b0;
      ev_cnt   <= '0;
      err_cnt  <= '0;
      newEvent <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      newEvent <= 1'b0;
      frameErr <= 1'b0;

      if (fall || timeout || state == IDLE) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end

      if (fall) begin
        case (eff_state)
          IDLE: begin
            bitcnt <= '0;
            state  <= dat_s2 ? IDLE : DATA;
          end
          DATA: begin
            shreg  <= {dat_s2, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par   <= dat_s2;
            state <= STOP;
          end
          default: state <= IDLE;
        endcase
      end else if (timeout) begin
        state <= IDLE;
      end

      if (frame_bad) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
        frameErr <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end else if (byte_ok) begin
        if (is_e0) begin
          ext_pend <= 1'b1;
        end else if (is_f0) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
          if (emit) begin
            ev_code  <= shreg;
            ev_brk   <= brk_pend;
            ev_ext   <= ext_pend;
            ev_cnt   <= ev_cnt + 8'd1;
            newEvent <= 1'b1;
          end
        end
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  // Remembers the last emitted make; a matching break forgets it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_make <= '0;
      last_vld  <= 1'b0;
    end else if (is_key) begin
      if (!brk_pend) begin
        last_make <= {ext_pend, shreg};
        last_vld  <= 1'b1;
      end else if (key_match) begin
        last_vld <= 1'b0;
      end
    end
  end
`endif

  assign ps2Data = {err_cnt, ev_cnt, 6'b0, ev_ext, ev_brk, ev_code};

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Randomized self-checking bench for ps2_keyboard_rx against a frame-level reference model.
module tb_ps2_keyboard_rx;

  localparam int unsigned TO_CYC = 300;
  localparam int unsigned HALF   = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2Clk = 1'b1;
  logic        ps2Dat = 1'b1;
  logic [31:0] ps2Data;
  logic        newEvent, frameErr;

  ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Dat(ps2Dat),
    .ps2Data(ps2Data), .newEvent(newEvent), .frameErr(frameErr)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: keyboard state tracked per received byte.
  logic [7:0]  m_cnt, m_err, m_code;
  logic        m_brk, m_ext, m_extp, m_brkp;
  logic [8:0]  m_last;
  logic        m_lv;
  int unsigned m_evp = 0, m_errp = 0;

  function automatic logic [31:0] m_word();
    return {m_err, m_cnt, 6'b0, m_ext, m_brk, m_code};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_err = 0; m_code = 0; m_brk = 0; m_ext = 0;
    m_extp = 0; m_brkp = 0; m_last = 0; m_lv = 0;
  endtask

  task automatic model_error();
    if (m_err != 8'd255) m_err = m_err + 8'd1;
    m_errp++;
    m_extp = 0; m_brkp = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic emit;
    if (b == 8'hE0) m_extp = 1;
    else if (b == 8'hF0) m_brkp = 1;
    else begin
      emit = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (!m_brkp) begin
        if (m_lv && m_last == {m_extp, b}) emit = 0;
        else begin m_last = {m_extp, b}; m_lv = 1; end
      end else if (m_lv && m_last == {m_extp, b}) begin
        m_lv = 0;
      end
`endif
      if (emit) begin
        m_cnt = m_cnt + 8'd1; m_code = b; m_brk = m_brkp; m_ext = m_extp; m_evp++;
      end
      m_extp = 0; m_brkp = 0;
    end
  endtask

  // Pulse monitor.
  int unsigned ev_seen = 0, err_seen = 0;
  logic [7:0]  prev_cnt = 8'd0;
  always @(negedge clk) begin
    if (reset) begin
      if (newEvent) begin
        ev_seen <= ev_seen + 1;
        chk("ev_cnt_step", {24'd0, ps2Data[23:16]}, {24'd0, prev_cnt + 8'd1});
      end
      if (frameErr) err_seen <= err_seen + 1;
      if (newEvent || frameErr) chk("pulse_excl", {31'd0, newEvent & frameErr}, 32'd0);
    end
    prev_cnt <= ps2Data[23:16];
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2Dat = b;
    cyc(HALF);
    ps2Clk = 1'b0;
    cyc(HALF);
    ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2Dat = 1'b1;
    cyc(HALF);
    if (bad_par || bad_stop) model_error();
    else model_byte(b);
  endtask

  task automatic send_partial(input logic [7:0] b, input int unsigned nbits);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) if (i < nbits) send_bit(b[i]);
    if (nbits > 8) send_bit(~^b);
    ps2Dat = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_word"}, ps2Data, m_word());
    chk({tag, "_evp"}, ev_seen, m_evp);
    chk({tag, "_errp"}, err_seen, m_errp);
  endtask

  int unsigned ev0;

  initial begin
    model_reset();
    // 1: reset
    cyc(2);
    reset = 1'b1;
    cyc(1);
    chk("rst_word", ps2Data, 32'h0);
    chk("rst_newEvent", {31'd0, newEvent}, 32'd0);
    chk("rst_frameErr", {31'd0, frameErr}, 32'd0);

    // 2..4
    send_frame(8'h1C, 0, 0);
    chk("t2", ps2Data, 32'h0001_001C); check_all("t2");
    send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
    chk("t3a", ps2Data, 32'h0002_011C); check_all("t3a");
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    chk("t3b", ps2Data, 32'h0003_0375); check_all("t3b");
    send_frame(8'h1C, 1, 0);
    chk("t4", ps2Data, 32'h0103_0375); check_all("t4");

    // 5: timeout after 5 data bits, then a clean frame, then a bad start bit
    send_partial(8'h1C, 5);
    cyc(TO_CYC + 60);
    model_error();
    chk("t5_to", ps2Data, 32'h0203_0375); check_all("t5_to");
    send_frame(8'h1C, 0, 0);
    chk("t5_next", ps2Data, 32'h0204_001C); check_all("t5_next");
    send_bit(1'b1);
    cyc(HALF);
    model_error();
    chk("badstart", ps2Data, 32'h0304_001C); check_all("badstart");

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      int unsigned r;
      logic [7:0]  b;
      r = $urandom_range(0, 15);
      case ($urandom_range(0, 4))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'h1C;
        3: b = 8'h75;
        default: b = 8'($urandom);
      endcase
      if (r == 0) send_frame(b, 1, 0);
      else if (r == 1) send_frame(b, 0, 1);
      else if (r == 2) begin
        send_partial(b, $urandom_range(0, 9));
        cyc(TO_CYC + 60);
        model_error();
      end else send_frame(b, 0, 0);
      check_all("rnd");
    end

    // Error count saturation via repeated bad start bits
    for (int k = 0; k < 260; k++) begin
      send_bit(1'b1);
      model_error();
    end
    cyc(HALF);
    chk("err_sat", {24'd0, ps2Data[31:24]}, 32'd255);
    check_all("sat");

    // Reset mid-frame: dropped silently
    send_partial(8'h5A, 3);
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    model_reset();
    cyc(TO_CYC + 60);
    chk("midrst_word", ps2Data, 32'h0);
    check_all("midrst");

    // 6: typematic repeats
    ev0 = ev_seen;
    send_frame(8'h1C, 0, 0); send_frame(8'h1C, 0, 0); send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("t6_word", ps2Data, 32'h0002_011C);
    chk("t6_events", ev_seen - ev0, 32'd2);
`else
    chk("t6_word", ps2Data, 32'h0004_011C);
    chk("t6_events", ev_seen - ev0, 32'd4);
`endif
    check_all("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
